arb2_sel_ctrl: RTL
==================

# arb2_sel_ctrl

Two-requester round-robin arbiter that generates the select and grant signals for the 2:1 data mux directly downstream of it. It ensures that only one source owns the mux output at a time. It also enforces fair alternation under contention and bounds how long either source may hold the grant. All outputs are registered, so the mux select never glitches.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles a grant may be held before forced release; 0 disables the limit.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  source A requests the mux output.
- req_b  in  1  source B requests the mux output.
- done  in  1  current owner releases the grant; sampled only while a grant is held.
- sel  out  1  mux select: 1 routes source A, 0 routes source B.
- gnt_a  out  1  A owns the output.
- gnt_b  out  1  B owns the output.
- busy  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- States:
  - IDLE: no grant.
  - OWN_A: gnt_a=1, sel=1.
  - OWN_B: gnt_b=1, sel=0.
- Internal `last` bit records the most recent owner. Reset value is B, so A wins the first tie.
- Reset: state IDLE, last=B, sel=0, gnt_a=gnt_b=0, busy=0, timeout=0, hold counter=0.
- IDLE transitions:
  - req_a only -> OWN_A.
  - req_b only -> OWN_B.
  - Both requesting -> the source that is not `last`.
  - Neither -> stay in IDLE.
  - done is ignored in IDLE.
- OWN_X release conditions (any one triggers release):
  - done=1;
  - req_X=0;
  - hold counter == MAX_HOLD-1 with MAX_HOLD != 0 (forced release).
- On release:
  - `last` is set to X.
  - If the other source is requesting in the same cycle, go directly to OWN_other (back-to-back handoff, no idle cycle).
  - Otherwise go to IDLE. X re-requesting alone is re-granted from IDLE, costing one bubble cycle.
- Hold counter: cleared on entry to any OWN state; increments each cycle the grant is held; saturates and never wraps.
- timeout is asserted for exactly one cycle, in the cycle after a forced release. A release caused by done or by request drop never asserts timeout, even if it coincides with the limit cycle.
- Invariants:
  - gnt_a and gnt_b are never high together.
  - busy = gnt_a | gnt_b.
  - In IDLE, sel holds its last value; it changes only on entry to an OWN state.
- Simultaneous events: if done and the limit fire in the same cycle, done takes precedence (no timeout).
- rst overrides all inputs. Asserting rst mid-grant drops the grant on the next edge and returns all outputs to reset values.

## Timing
- Request to grant from IDLE: 1 cycle. A request sampled at edge n gives gnt high after edge n.
- Handoff: done at edge n gives old grant low and new grant high after the same edge n. There is no overlap and no gap.
- Maximum grant length with MAX_HOLD=M: M cycles.
- sel and gnt_x change on the same edge.
- Fairness bound: with both sources requesting continuously, ownership alternates A, B, A, B, …, each owner holding at most M cycles.
- All outputs are flop outputs; there is no combinational path from any input to any output.

## Test plan
- Reset, then req_a=1 only from cycle 2 -> gnt_a=1, sel=1, busy=1 at cycle 3; drop req_a at cycle 6 -> IDLE at cycle 7, sel stays 1.
- Both req_a and req_b high from cycle 2 with done pulsed every 4 cycles -> grant order A, B, A, B; each handoff has zero idle cycles; gnt_a&gnt_b never 1.
- MAX_HOLD=16, req_a held high, done=0 -> gnt_a high for exactly 16 cycles, then drops. timeout=1 for one cycle and gnt_b follows if req_b is high, else IDLE.
- done and the limit coincide in cycle 16 -> release occurs and timeout stays 0.
- rst asserted in cycle 3 of an OWN_B grant -> next cycle gnt_b=0, sel=0, busy=0, last=B, so an A/B tie afterward grants A.
- MAX_HOLD=0, req_b held for 100 cycles -> gnt_b held throughout and timeout never asserts.

Source files
------------

// File: rtl/arb2_sel_ctrl_if.sv
// Request/grant bundle between two mux sources and the 2:1 select arbiter.
// The arbiter connects through the slave modport; the requesting side uses master.
interface arb2_sel_ctrl_if;
   logic req_a;
   logic req_b;
   logic done;
   logic sel;
   logic gnt_a;
   logic gnt_b;
   logic busy;
   logic timeout;

   modport master (
      output req_a, req_b, done,
      input  sel, gnt_a, gnt_b, busy, timeout
   );

   modport slave (
      input  req_a, req_b, done,
      output sel, gnt_a, gnt_b, busy, timeout
   );
endinterface

// File: rtl/arb2_sel_ctrl.sv
// Two-source round-robin arbiter that drives the 2:1 mux select and grants.
// Every output is a flop, so the select cannot glitch.
module arb2_sel_ctrl #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic            clk,
   input  logic            rst,
   arb2_sel_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   logic             last_a;
   logic [CNT_W-1:0] hold_cnt;
   logic             sel_q;
   logic             gnt_a_q;
   logic             gnt_b_q;
   logic             busy_q;
   logic             timeout_q;
   logic             limit_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_a    <= 1'b0;
         hold_cnt  <= '0;
         sel_q     <= 1'b0;
         gnt_a_q   <= 1'b0;
         gnt_b_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               // On a tie the source that did not own last wins.
               if (bus.req_a && (!bus.req_b || !last_a)) begin
                  state    <= OWN_A;
                  gnt_a_q  <= 1'b1;
                  sel_q    <= 1'b1;
                  busy_q   <= 1'b1;
                  hold_cnt <= '0;
               end else if (bus.req_b) begin
                  state    <= OWN_B;
                  gnt_b_q  <= 1'b1;
                  sel_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            OWN_A: begin
               if (bus.done || !bus.req_a || limit_hit) begin
                  last_a    <= 1'b1;
                  timeout_q <= limit_hit && !bus.done && bus.req_a;
                  gnt_a_q   <= 1'b0;
                  if (bus.req_b) begin
                     state    <= OWN_B;
                     gnt_b_q  <= 1'b1;
                     sel_q    <= 1'b0;
                     hold_cnt <= '0;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  hold_cnt <= sat_inc(hold_cnt);
               end
            end
            OWN_B: begin
               if (bus.done || !bus.req_b || limit_hit) begin
                  last_a    <= 1'b0;
                  timeout_q <= limit_hit && !bus.done && bus.req_b;
                  gnt_b_q   <= 1'b0;
                  if (bus.req_a) begin
                     state    <= OWN_A;
                     gnt_a_q  <= 1'b1;
                     sel_q    <= 1'b1;
                     hold_cnt <= '0;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  hold_cnt <= sat_inc(hold_cnt);
               end
            end
            default: begin
               state   <= IDLE;
               gnt_a_q <= 1'b0;
               gnt_b_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sel     = sel_q;
   assign bus.gnt_a   = gnt_a_q;
   assign bus.gnt_b   = gnt_b_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule
